// File: rtl/lzd_pkg.sv
// Shared constants and helpers for the pipelined leading-zero/one counter.
// Derived tree geometry is computed here so the top level and users agree on latency.
package lzd_pkg;

  localparam logic LZD_MODE_CLZ = 1'b0;
  localparam logic LZD_MODE_CLO = 1'b1;

  function automatic int lzd_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Operand width rounded up to a power of two so the merge tree is balanced.
  function automatic int lzd_pw(input int width);
    return 1 << lzd_clog2(width);
  endfunction

  function automatic int lzd_levels(input int width);
    return lzd_clog2(lzd_pw(width));
  endfunction

  function automatic int lzd_nstg(input int width, input int lvl_per_stage);
    return (lzd_levels(width) + lvl_per_stage - 1) / lvl_per_stage;
  endfunction

  function automatic int lzd_lat(input int width, input int lvl_per_stage);
    return 1 + lzd_nstg(width, lvl_per_stage);
  endfunction

  function automatic int lzd_cw(input int width);
    return lzd_clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzd_pipe_merge.sv
// Combinational LZD merge node: joins two K-bit half results into one K+1-bit result.
// Zero latency; no flow control of its own.
module lzd_merge #(
  parameter int K = 1
) (
  input  logic         vl,
  input  logic [K-1:0] pl,
  input  logic         vr,
  input  logic [K-1:0] pr,
  output logic         v,
  output logic [K:0]   p
);

  // A hit in the upper half wins; otherwise the count skips the whole upper half.
  assign v = vl | vr;
  assign p = vl ? {1'b0, pl} : {1'b1, pr};

endmodule

// File: rtl/lzd_pipe.sv
// Pipelined leading-zero/one counter with sideband tag, latency 1 + ceil(levels/LVL_PER_STAGE).
// Whole pipe advances only when the output slot is empty or drained; in_ready = that advance.
module lzd_pipe
  import lzd_pkg::*;
#(
  parameter  int WIDTH         = 48,
  parameter  int LVL_PER_STAGE = 2,
  parameter  int TAG_W         = 8,
  localparam int CW            = lzd_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW     = lzd_pw(WIDTH);
  localparam int LEVELS = lzd_levels(WIDTH);
  localparam int NSTG   = lzd_nstg(WIDTH, LVL_PER_STAGE);

  logic             adv;
  logic [NSTG:0]    vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [NSTG+1];
  logic [TAG_W-1:0] tag_d [NSTG+1];
  logic [WIDTH-1:0] data_q, data_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] op;
  logic [PW-1:0]    op_al;

  assign adv      = ~vld_q[NSTG] | out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    mode_d = mode_q;
    tag_d  = tag_q;
    if (adv) begin
      vld_d    = {vld_q[NSTG-1:0], in_valid};
      data_d   = in_data;
      mode_d   = in_mode;
      tag_d[0] = in_tag;
      for (int s = 1; s <= NSTG; s++) tag_d[s] = tag_q[s-1];
    end
  end

  // Invert before padding so the zero-filled LSBs can never register as a hit.
  assign op    = (mode_q == LZD_MODE_CLO) ? ~data_q : data_q;
  assign op_al = PW'(op) << (PW - WIDTH);

  for (genvar l = 1; l <= LEVELS; l++) begin : gen_lvl
    localparam int N = PW >> l;
    logic [N-1:0]   v_c, v_f;
    logic [N*l-1:0] p_c, p_f;

    if (l == 1) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_node
        assign v_c[i] = op_al[2*i+1] | op_al[2*i];
        assign p_c[i] = ~op_al[2*i+1] & op_al[2*i];
      end
    end else begin : g_merge
      for (genvar i = 0; i < N; i++) begin : g_node
        lzd_merge #(.K(l-1)) u_merge (
          .vl (gen_lvl[l-1].v_f[2*i+1]),
          .pl (gen_lvl[l-1].p_f[(2*i+1)*(l-1) +: (l-1)]),
          .vr (gen_lvl[l-1].v_f[2*i]),
          .pr (gen_lvl[l-1].p_f[(2*i)*(l-1) +: (l-1)]),
          .v  (v_c[i]),
          .p  (p_c[i*l +: l])
        );
      end
    end

    // The root is registered separately as count/zero so reset values are all-zero.
    if ((l % LVL_PER_STAGE == 0) && (l != LEVELS)) begin : g_reg
      logic [N-1:0]   v_q, v_d;
      logic [N*l-1:0] p_q, p_d;

      always_comb begin
        v_d = v_q;
        p_d = p_q;
        if (adv) begin
          v_d = v_c;
          p_d = p_c;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          p_q <= '0;
        end else begin
          v_q <= v_d;
          p_q <= p_d;
        end
      end

      assign v_f = v_q;
      assign p_f = p_q;
    end else begin : g_wire
      assign v_f = v_c;
      assign p_f = p_c;
    end
  end

  always_comb begin
    count_d = count_q;
    zero_d  = zero_q;
    if (adv) begin
      zero_d  = ~gen_lvl[LEVELS].v_f[0];
      count_d = gen_lvl[LEVELS].v_f[0] ? CW'(gen_lvl[LEVELS].p_f) : CW'(WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
      zero_q  <= 1'b0;
      for (int s = 0; s <= NSTG; s++) tag_q[s] <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      for (int s = 0; s <= NSTG; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign out_valid = vld_q[NSTG];
  assign out_count = count_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q[NSTG];

endmodule
